// File: rtl/pc_run_ctrl.sv
// Debug run-control sequencer: owns the commit enable, halt/resume/step, PC breakpoints.
// Optional instruction-limit halt enabled by defining PC_RUN_CTRL_INSTR_LIMIT_EN.
module pc_run_ctrl #(
  parameter int NUM_BP = 2,
  parameter int CNT_W  = 32,
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_pc,
  input  logic             i_halt_req,
  input  logic             i_resume_req,
  input  logic             i_step_req,
  input  logic             i_bp_we,
  input  logic [IDX_W-1:0] i_bp_idx,
  input  logic [31:0]      i_bp_addr,
  input  logic             i_bp_valid,
`ifdef PC_RUN_CTRL_INSTR_LIMIT_EN
  input  logic [CNT_W-1:0] i_limit,
`endif
  output logic             o_commit_en,
  output logic             o_halted,
  output logic [1:0]       o_halt_cause,
  output logic [31:0]      o_halt_pc,
  output logic [CNT_W-1:0] o_instr_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_REQ   = 2'b00,
    CAUSE_BP    = 2'b01,
    CAUSE_STEP  = 2'b10,
    CAUSE_LIMIT = 2'b11
  } cause_t;

  state_t      state, state_next;
  logic        skip, skip_next;
  logic [1:0]  cause_next;
  logic        commit_raw;
  logic        bp_match;
  logic        bp_hit;
  logic [31:0] bp_addr  [NUM_BP];
  logic        bp_valid [NUM_BP];

  always_comb begin
    bp_match = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (bp_valid[i] && (bp_addr[i] == i_pc)) bp_match = 1'b1;
    end
  end

  assign bp_hit = bp_match & ~skip;

`ifdef PC_RUN_CTRL_INSTR_LIMIT_EN
  logic limit_hit;
  assign limit_hit = (i_limit != '0) && (o_instr_cnt == i_limit) && !skip;
`endif

  // The first RUN cycle after leaving HALT always commits, so neither the
  // breakpoint on the halted PC nor a held halt request can re-halt at once.
  always_comb begin
    state_next = state;
    cause_next = o_halt_cause;
    commit_raw = 1'b0;
    unique case (state)
      RUN: begin
        if (skip) begin
          commit_raw = 1'b1;
        end else if (bp_hit) begin
          state_next = HALT;
          cause_next = CAUSE_BP;
`ifdef PC_RUN_CTRL_INSTR_LIMIT_EN
        end else if (limit_hit) begin
          state_next = HALT;
          cause_next = CAUSE_LIMIT;
`endif
        end else if (i_halt_req) begin
          state_next = HALT;
          cause_next = CAUSE_REQ;
        end else begin
          commit_raw = 1'b1;
        end
      end
      HALT: begin
        if (i_step_req)        state_next = STEP;
        else if (i_resume_req) state_next = RUN;
      end
      STEP: begin
        commit_raw = 1'b1;
        state_next = HALT;
        cause_next = CAUSE_STEP;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    skip_next = skip;
    if ((state == HALT) && (state_next != HALT)) skip_next = 1'b1;
    else if (state == RUN)                       skip_next = 1'b0;
  end

  // Reset gates commit combinationally so nothing retires while it is held.
  assign o_commit_en = commit_raw & i_rst;
  assign o_halted    = (state == HALT);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= RUN;
      skip         <= 1'b0;
      o_halt_cause <= CAUSE_REQ;
      o_halt_pc    <= '0;
      o_instr_cnt  <= '0;
    end else begin
      state <= state_next;
      skip  <= skip_next;
      if ((state_next == HALT) && (state != HALT)) o_halt_cause <= cause_next;
      if (!o_commit_en) o_halt_pc   <= i_pc;
      else              o_instr_cnt <= o_instr_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned i = 0; i < NUM_BP; i++) begin
        bp_addr[i]  <= '0;
        bp_valid[i] <= 1'b0;
      end
    end else if (i_bp_we && (int'(i_bp_idx) < NUM_BP)) begin
      bp_addr[i_bp_idx]  <= i_bp_addr;
      bp_valid[i_bp_idx] <= i_bp_valid;
    end
  end

endmodule

// File: doc/pc_run_ctrl.md
Name: pc_run_ctrl

Overview:
Debug run-control sequencer for the single-cycle core. It owns the global commit enable that gates the PC register and all architectural writes (register file, data memory). It implements halt, resume, single-step and a small PC breakpoint table. It reports the halted PC and a retired-instruction count to the debug path.

Parameters:
NUM_BP, 2, number of PC breakpoint entries (1..8)
CNT_W, 32, width of retired-instruction counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-low reset
i_pc  in  32  current PC from the PC register
i_halt_req  in  1  level; request halt
i_resume_req  in  1  level; leave HALT and run
i_step_req  in  1  level; execute exactly one instruction from HALT
i_bp_we  in  1  breakpoint table write strobe
i_bp_idx  in  $clog2(NUM_BP) (min 1)  entry index
i_bp_addr  in  32  breakpoint PC
i_bp_valid  in  1  enable bit written with the entry
o_commit_en  out  1  1 = current instruction commits (PC/regfile/mem update)
o_halted  out  1  1 while in HALT
o_halt_cause  out  2  00 halt_req, 01 breakpoint, 10 step, 11 limit
o_halt_pc  out  32  PC at which the core is stopped
o_instr_cnt  out  CNT_W  retired instructions (cycles with o_commit_en=1)

Behaviour:
- Reset (i_rst=0, async): state RUN, skip flag 0, all breakpoint entries invalid and address 0, o_halt_cause=00, o_halt_pc=0, o_instr_cnt=0, o_halted=0.
- States: RUN, HALT, STEP (2-bit register). o_halted = (state==HALT), registered.
- bp_hit (combinational): any valid entry with addr == i_pc (full 32-bit compare), masked to 0 when the skip flag is 1.
- RUN, evaluated in priority order:
  - bp_hit: o_commit_en=0; next state HALT; cause 01.
  - else i_halt_req: o_commit_en=0; next state HALT; cause 00.
  - else o_commit_en=1; stay in RUN.
  - The halting instruction does not commit.
- HALT: o_commit_en=0.
  - i_step_req: next state STEP (step wins over simultaneous resume).
  - else i_resume_req: next state RUN with skip flag set.
  - i_halt_req is ignored.
- STEP: o_commit_en=1 for exactly this cycle; breakpoints and i_halt_req ignored; next state HALT; cause 10.
- Skip flag: set on HALT->RUN and on entering STEP, cleared after one RUN cycle. Prevents an immediate re-halt at a breakpoint on the halted PC.
- o_halt_cause is updated only on transitions into HALT.
- o_halt_pc loads i_pc on every rising edge where o_commit_en=0.
  - After a step, it shows the new PC one cycle after entering HALT.
- o_instr_cnt increments on every rising edge where o_commit_en=1; wraps modulo 2^CNT_W.
- Breakpoint write: on an edge with i_bp_we=1, entry[i_bp_idx] <= {i_bp_valid, i_bp_addr}.
  - Visible to the compare from the next cycle.
  - An index >= NUM_BP is ignored.
  - A write in the same cycle as a hit does not affect that cycle's compare.
- Held request levels: a held i_step_req steps once per two cycles (STEP, HALT, STEP...). A held i_halt_req after resume halts after one committed instruction.
- Reset mid-STEP or mid-RUN returns to the reset state immediately; no commit occurs after reset assertion.

Optional Feature:
PC_RUN_CTRL_INSTR_LIMIT_EN
- Defined:
  - Adds input i_limit [CNT_W-1:0].
  - In RUN, when i_limit != 0, o_instr_cnt == i_limit and the skip flag is 0: o_commit_en=0; next state HALT; cause 11.
  - Priority: below breakpoint, above i_halt_req.
  - Equality only, so after resume the count exceeds the limit and no re-trigger occurs.
- Undefined: port absent; cause 11 never produced.

Test Plan:
- Reset then release, i_pc stepping 0x0,0x4,0x8 -> o_commit_en=1 each cycle; o_instr_cnt=3 after 3 edges; o_halted=0, o_halt_pc=0.
- Write bp0=0x0000_0010 valid, run to i_pc=0x10 -> o_commit_en=0 that cycle; next cycle o_halted=1, cause=01, o_halt_pc=0x10; count unchanged.
- From breakpoint halt, pulse i_resume_req one cycle -> RUN; instruction at 0x10 commits (skip flag); o_instr_cnt+1; no re-halt.
- In HALT at 0x20, pulse i_step_req -> exactly one commit cycle; then HALT, cause=10, o_halt_pc=0x24 one cycle later.
- i_halt_req and bp hit in the same RUN cycle -> cause=01. Simultaneous resume+step in HALT -> STEP taken.
- Assert i_rst=0 while in STEP -> o_commit_en=0 and o_halted=0 immediately; all bp entries invalid; counter 0.
